pulse_meter: RTL

Receive-side companion to the on-chip square-wave generator: measures an incoming single-bit periodic signal, reporting period and high time in clock cycles with a per-edge valid strobe, a lock flag and a loss-of-signal flag. It sits on the sampling side of generator outputs (or external pulse inputs) and lets a testbench or control logic confirm the generated frequency and duty cycle on-chip.

---
 rtl/pulse_meter_pkg.sv | 14 +
 rtl/pulse_meter_sync_edge.sv | 32 +++
 rtl/pulse_meter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared configuration for the pulse generator / pulse meter pair:
// FSM state encoding and the default counter width and loss-of-signal limit.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } pm_state_e;

  localparam int PM_N       = 26;
  localparam int PM_TIMEOUT = 60000000;

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous single-bit input, followed by a
// delay flop so a one-cycle rising-edge pulse can be derived. Reusable for
// any asynchronous level input.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic f,
  output logic level,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // synchronizer chain plus edge-detect delay stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= f;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures period and high time of an asynchronous periodic input in clk
// cycles, publishing both on every rising edge once a reference edge exists.
// Also flags a stable signal (locked) and loss of signal (timeout).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for the first reference edge
// MEASURE | reference edge seen, each further rise publishes a result
// LOST    | no rise for TIMEOUT cycles, next rise re-arms measuring
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int N       = PM_N,
  parameter int TIMEOUT = PM_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         f,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [N-1:0] TO_C  = N'(TIMEOUT);
  localparam logic [N-1:0] ONE   = N'(1);
  localparam logic [N-1:0] MAX_C = '1;

  logic level;
  logic rise;

  logic [N-1:0] per_cnt_q, per_cnt_d;
  logic [N-1:0] high_cnt_q, high_cnt_d;
  pm_state_e    state_q, state_d;

  logic [N-1:0] period_q, period_d;
  logic [N-1:0] high_time_q, high_time_d;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         timeout_q, timeout_d;
  // a publish has happened since the last IDLE/LOST, so locked may compare
  logic         have_ref_q, have_ref_d;

  logic         to_hit;
  logic [N-1:0] period_new;

  sync_edge u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .f     (f),
    .level (level),
    .rise  (rise)
  );

  // rise takes priority over the timeout condition
  assign to_hit     = (per_cnt_q == TO_C) & ~rise;
  assign period_new = per_cnt_q + ONE;

  // period and high-time counters, restarted by each rise
  always_comb begin
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    if (rise) begin
      per_cnt_d  = '0;
      high_cnt_d = ONE;
    end else begin
      if (per_cnt_q != TO_C) per_cnt_d = per_cnt_q + ONE;
      if (level && (high_cnt_q != MAX_C)) high_cnt_d = high_cnt_q + ONE;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = MEASURE; else if (to_hit) state_d = LOST;
      MEASURE: if (to_hit) state_d = LOST;
      LOST:    if (rise) state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: publish, lock compare and loss-of-signal flag
  always_comb begin
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_ref_d  = have_ref_q;
    unique case (state_q)
      IDLE, MEASURE: begin
        if (rise && (state_q == MEASURE)) begin
          period_d    = period_new;
          high_time_d = high_cnt_q;
          valid_d     = 1'b1;
          locked_d    = have_ref_q && (period_new == period_q)
                                   && (high_cnt_q == high_time_q);
          have_ref_d  = 1'b1;
        end else if (to_hit) begin
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          have_ref_d = 1'b0;
        end
      end
      LOST: begin
        if (rise) timeout_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_ref_q  <= 1'b0;
    end else begin
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_ref_q  <= have_ref_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
